// File: rtl/sram_pkg.sv
// Shared definitions for controllers on the external SRAM bank.
//   sram_state_e : access sequencer states
//   sram_owner_e : which pipeline port owns the access in flight
//   CE_N_IDLE / BE_N_IDLE : inactive levels of the active-low chip/byte strobes
package sram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_WR_HOLD,
    ST_DONE
  } sram_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_MEM
  } sram_owner_e;

  localparam logic CE_N_IDLE = 1'b1;
  // Per-lane inactive level; replicate across the byte-enable bus.
  localparam logic BE_N_IDLE = 1'b1;

endpackage

// File: rtl/sram_port_arbiter.sv
// Shares one asynchronous SRAM bank between the instruction-fetch port and the
// data-memory port. Fixed priority (MEM over IF), multi-cycle strobe timing,
// one-cycle ack with read data. Every output is a flop.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   if_req/if_addr            fetch read request (level, held until if_ack)
//   if_rdata/if_ack           fetch data, valid with the one-cycle ack
//   mem_req/we/be/addr/wdata  data request (level, held until mem_ack)
//   mem_rdata/mem_ack         data read data, valid with the one-cycle ack
//   sram_dout                 data from the pad buffer
//   sram_din/sram_dq_oe       data to the pad buffer and its drive enable
//   sram_addr, sram_be_n, sram_ce_n, sram_oe_n, sram_we_n  SRAM pins
module sram_port_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 32,
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [DATA_W/8-1:0] mem_be,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_ack,
  input  logic [DATA_W-1:0]   sram_dout,
  output logic [DATA_W-1:0]   sram_din,
  output logic                sram_dq_oe,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W/8-1:0] sram_be_n,
  output logic                sram_ce_n,
  output logic                sram_oe_n,
  output logic                sram_we_n
);

  localparam int BE_W    = DATA_W / 8;
  localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);
  localparam logic [BE_W-1:0]  BE_OFF  = {BE_W{BE_N_IDLE}};

  sram_state_e      state;
  sram_owner_e      owner;
  logic [CNT_W-1:0] cnt;

  // Strobes are driven from the state transitions themselves so each pin is a
  // flop whose value matches the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_IF;
      cnt        <= '0;
      if_ack     <= 1'b0;
      mem_ack    <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      sram_addr  <= '0;
      sram_din   <= '0;
      sram_dq_oe <= 1'b0;
      sram_be_n  <= BE_OFF;
      sram_ce_n  <= CE_N_IDLE;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          // MEM holds the older instruction, so it wins a tie.
          if (mem_req) begin
            owner     <= OWN_MEM;
            sram_addr <= mem_addr;
            sram_ce_n <= 1'b0;
            if (mem_we) begin
              state      <= ST_WR;
              cnt        <= WR_LOAD;
              sram_we_n  <= 1'b0;
              sram_be_n  <= ~mem_be;
              sram_din   <= mem_wdata;
              sram_dq_oe <= 1'b1;
            end else begin
              state     <= ST_RD;
              cnt       <= RD_LOAD;
              sram_oe_n <= 1'b0;
              sram_be_n <= '0;
            end
          end else if (if_req) begin
            owner     <= OWN_IF;
            sram_addr <= if_addr;
            sram_ce_n <= 1'b0;
            sram_oe_n <= 1'b0;
            sram_be_n <= '0;
            state     <= ST_RD;
            cnt       <= RD_LOAD;
          end
        end
        ST_RD: begin
          if (cnt == '0) begin
            if (owner == OWN_MEM) begin
              mem_rdata <= sram_dout;
              mem_ack   <= 1'b1;
            end else begin
              if_rdata <= sram_dout;
              if_ack   <= 1'b1;
            end
            sram_ce_n <= CE_N_IDLE;
            sram_oe_n <= 1'b1;
            sram_be_n <= BE_OFF;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WR: begin
          // Raise we_n first; ce_n, address, data and drive stay for hold time.
          if (cnt == '0) begin
            sram_we_n <= 1'b1;
            state     <= ST_WR_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WR_HOLD: begin
          sram_ce_n  <= CE_N_IDLE;
          sram_be_n  <= BE_OFF;
          sram_dq_oe <= 1'b0;
          mem_ack    <= 1'b1;  // only MEM ever writes
          state      <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
